// File: rtl/bbox_overlay_pkg.sv
// Shared types and constants for the bounding-box overlay block.
package bbox_overlay_pkg;

    localparam int          COORD_W           = 16;
    localparam logic [23:0] DEFAULT_BOX_COLOR = 24'h00FF00;

    // One rectangle, inclusive corners in pixel coordinates.
    typedef struct packed {
        logic [COORD_W-1:0] x_start;
        logic [COORD_W-1:0] y_start;
        logic [COORD_W-1:0] x_end;
        logic [COORD_W-1:0] y_end;
    } bbox_t;

endpackage

// File: rtl/bbox_overlay_edge_hit.sv
// Decides whether one pixel lies on the outline of one box.
// The band tests use a 17-bit compare so that start+T cannot wrap and
// end-T+1 is never formed, which keeps the bands clamped to the box.
module bbox_edge_hit
    import bbox_overlay_pkg::*;
(
    input  bbox_t              box_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [COORD_W-1:0] thick_i,
    output logic               hit_o
);

    logic [COORD_W:0] x_w, y_w, t_w;
    logic             inside_x, inside_y;
    logic             near_top, near_bot, near_left, near_right;

    assign x_w = {1'b0, x_i};
    assign y_w = {1'b0, y_i};
    assign t_w = {1'b0, thick_i};

    assign inside_x = (x_i >= box_i.x_start) && (x_i <= box_i.x_end);
    assign inside_y = (y_i >= box_i.y_start) && (y_i <= box_i.y_end);

    // y < ys+T  <=>  y <= ys+T-1 ;  y+T > ye  <=>  y >= ye-T+1
    assign near_top   = y_w < ({1'b0, box_i.y_start} + t_w);
    assign near_bot   = (y_w + t_w) > {1'b0, box_i.y_end};
    assign near_left  = x_w < ({1'b0, box_i.x_start} + t_w);
    assign near_right = (x_w + t_w) > {1'b0, box_i.x_end};

    assign hit_o = inside_x && inside_y &&
                   (near_top || near_bot || near_left || near_right);

endmodule

// File: rtl/bbox_overlay.sv
// Bounding-box overlay: collects detector boxes into a write bank, swaps
// it to the display bank at the next frame start after the detector
// signals done, and paints box outlines over the video with 2-cycle latency.
module bbox_overlay
    import bbox_overlay_pkg::*;
#(
    parameter int          IMAGE_WIDTH    = 1280,
    parameter int          IMAGE_HEIGHT   = 720,
    parameter int          MAX_BOXES      = 16,
    parameter int          LINE_THICKNESS = 2,
    parameter logic [23:0] BOX_COLOR      = DEFAULT_BOX_COLOR,
    localparam int         CNT_W          = $clog2(MAX_BOXES + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               bbox_valid,
    input  logic [15:0]        bbox_x_start,
    input  logic [15:0]        bbox_y_start,
    input  logic [15:0]        bbox_x_end,
    input  logic [15:0]        bbox_y_end,
    input  logic               done,
    input  logic               de,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [7:0]         r,
    input  logic [7:0]         g,
    input  logic [7:0]         b,
    output logic               de_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic [7:0]         r_out,
    output logic [7:0]         g_out,
    output logic [7:0]         b_out,
    output logic [CNT_W-1:0]   box_count,
    output logic               overflow
);

    localparam int                 IDX_W = (MAX_BOXES > 1) ? $clog2(MAX_BOXES) : 1;
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(IMAGE_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(IMAGE_HEIGHT - 1);
    localparam logic [COORD_W-1:0] THICK = COORD_W'(LINE_THICKNESS);
    localparam logic [CNT_W-1:0]   FULL  = CNT_W'(MAX_BOXES);

    // Timing edge detection
    logic vsync_q, de_q;
    logic frame_start, de_fall;

    // Pixel coordinates of the pixel currently on the inputs
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

    // Box storage and bookkeeping; bank_sel_q names the display bank
    bbox_t            bank_q [2][MAX_BOXES];
    logic             bank_sel_q, bank_sel_d;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;
    logic [CNT_W-1:0] disp_count_q, disp_count_d;
    logic             committed_q, committed_d;
    logic             overflow_q, overflow_d;
    bbox_t            new_box;
    logic             box_ok, wr_en;

    // Hit evaluation
    logic [MAX_BOXES-1:0] hit_vec;

    // Pipeline stage 1 and stage 2 registers
    logic        de1_q, hs1_q, vs1_q, hit1_q;
    logic [23:0] rgb1_q;
    logic        de2_q, hs2_q, vs2_q;
    logic [23:0] rgb2_q;

    assign frame_start = vsync & ~vsync_q;
    assign de_fall     = de_q & ~de;

    assign new_box = '{x_start: bbox_x_start, y_start: bbox_y_start,
                       x_end:   bbox_x_end,   y_end:   bbox_y_end};

    assign box_ok = (bbox_x_start <= bbox_x_end) && (bbox_y_start <= bbox_y_end) &&
                    (bbox_x_end <= X_MAX) && (bbox_y_end <= Y_MAX);

    assign wr_en = bbox_valid && !committed_q && box_ok && (wr_count_q < FULL);

    // Next pixel coordinates: x counts active pixels, y counts lines
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        x_d = x_q;
        y_d = y_q;
        if (de) begin
            if (x_q < X_MAX) x_d = x_q + COORD_W'(1);
        end else if (de_fall) begin
            x_d = '0;
        end
        if (frame_start) begin
            y_d = '0;
        end else if (de_fall && (y_q < Y_MAX)) begin
            y_d = y_q + COORD_W'(1);
        end
    end

    // Next bank bookkeeping: store, commit, then swap at frame start
    always_comb begin
        wr_count_d   = wr_count_q;
        disp_count_d = disp_count_q;
        committed_d  = committed_q;
        overflow_d   = overflow_q;
        bank_sel_d   = bank_sel_q;

        if (wr_en) begin
            wr_count_d = wr_count_q + CNT_W'(1);
        end else if (bbox_valid && !committed_q && (wr_count_q == FULL)) begin
            overflow_d = 1'b1;
        end

        if (done) committed_d = 1'b1;

        // A box in the frame-start cycle is already dropped by committed_q.
        if (frame_start && committed_q) begin
            bank_sel_d   = ~bank_sel_q;
            disp_count_d = wr_count_q;
            wr_count_d   = '0;
            committed_d  = 1'b0;
            overflow_d   = 1'b0;
        end
    end

    // Control and coordinate state registers
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!reset_n) begin
            vsync_q      <= 1'b0;
            de_q         <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            bank_sel_q   <= 1'b0;
            wr_count_q   <= '0;
            disp_count_q <= '0;
            committed_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            de_q         <= de;
            x_q          <= x_d;
            y_q          <= y_d;
            bank_sel_q   <= bank_sel_d;
            wr_count_q   <= wr_count_d;
            disp_count_q <= disp_count_d;
            committed_q  <= committed_d;
            overflow_q   <= overflow_d;
        end
    end

    // Box write into the bank not currently displayed
    always_ff @(posedge clk) begin
        // NOTE: bank contents are not reset; the counts gate every entry, so
        // stale data is never observed and the storage stays plain RAM.
        if (wr_en) begin
            bank_q[~bank_sel_q][wr_count_q[IDX_W-1:0]] <= new_box;
        end
    end

    // One outline checker per display-bank entry, masked by the count
    for (genvar i = 0; i < MAX_BOXES; i++) begin : g_hit
        bbox_t disp_box;
        logic  raw_hit;

        assign disp_box = bank_q[bank_sel_q][i];

        bbox_edge_hit u_edge_hit (
            .box_i   (disp_box),
            .x_i     (x_q),
            .y_i     (y_q),
            .thick_i (THICK),
            .hit_o   (raw_hit)
        );

        assign hit_vec[i] = raw_hit & (CNT_W'(i) < disp_count_q);
    end

    // Two-stage video pipeline: stage 1 registers the hit, stage 2 muxes colour
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de1_q  <= 1'b0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            hit1_q <= 1'b0;
            rgb1_q <= '0;
            de2_q  <= 1'b0;
            hs2_q  <= 1'b0;
            vs2_q  <= 1'b0;
            rgb2_q <= '0;
        end else begin
            de1_q  <= de;
            hs1_q  <= hsync;
            vs1_q  <= vsync;
            hit1_q <= de & (|hit_vec);
            rgb1_q <= {r, g, b};
            de2_q  <= de1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            rgb2_q <= hit1_q ? BOX_COLOR : rgb1_q;
        end
    end

    assign de_out    = de2_q;
    assign hsync_out = hs2_q;
    assign vsync_out = vs2_q;
    assign r_out     = rgb2_q[23:16];
    assign g_out     = rgb2_q[15:8];
    assign b_out     = rgb2_q[7:0];
    assign box_count = disp_count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_bbox_overlay.sv
// Testbench for bbox_overlay: directed frames, a per-cycle scoreboard of
// expected video outputs, and direct checks of box_count / overflow.
module tb_bbox_overlay;

    localparam int          W        = 1280;
    localparam int          H        = 720;
    localparam int          MAXB     = 16;
    localparam int          T        = 2;
    localparam logic [23:0] COLOR    = 24'h00FF00;
    localparam int          CW       = $clog2(MAXB + 1);
    localparam int          LINE_LEN = 170;
    localparam int          NLINES   = 180;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          bbox_valid;
    logic [15:0]   bbox_x_start, bbox_y_start, bbox_x_end, bbox_y_end;
    logic          done;
    logic          de, hsync, vsync;
    logic [7:0]    r, g, b;
    logic          de_out, hsync_out, vsync_out;
    logic [7:0]    r_out, g_out, b_out;
    logic [CW-1:0] box_count;
    logic          overflow;

    bbox_overlay #(
        .IMAGE_WIDTH    (W),
        .IMAGE_HEIGHT   (H),
        .MAX_BOXES      (MAXB),
        .LINE_THICKNESS (T),
        .BOX_COLOR      (COLOR)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bbox_valid   (bbox_valid),
        .bbox_x_start (bbox_x_start),
        .bbox_y_start (bbox_y_start),
        .bbox_x_end   (bbox_x_end),
        .bbox_y_end   (bbox_y_end),
        .done         (done),
        .de           (de),
        .hsync        (hsync),
        .vsync        (vsync),
        .r            (r),
        .g            (g),
        .b            (b),
        .de_out       (de_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .r_out        (r_out),
        .g_out        (g_out),
        .b_out        (b_out),
        .box_count    (box_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [26:0] vec;
        int          px;
        int          py;
    } exp_t;

    typedef struct {
        int xs;
        int ys;
        int xe;
        int ye;
    } tbox_t;

    exp_t  sb_q[$];
    tbox_t disp_model[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Outline model written from the inclusive, clamped band definitions.
    function automatic bit model_hit(input int px, input int py);
        foreach (disp_model[i]) begin
            int xs, ys, xe, ye, top_hi, bot_lo, left_hi, right_lo;
            bit in_x, in_y, on_row, on_col;
            xs = disp_model[i].xs; ys = disp_model[i].ys;
            xe = disp_model[i].xe; ye = disp_model[i].ye;
            top_hi   = (ys + T - 1 < ye) ? ys + T - 1 : ye;
            bot_lo   = (ye - T + 1 > ys) ? ye - T + 1 : ys;
            left_hi  = (xs + T - 1 < xe) ? xs + T - 1 : xe;
            right_lo = (xe - T + 1 > xs) ? xe - T + 1 : xs;
            in_x   = (px >= xs) && (px <= xe);
            in_y   = (py >= ys) && (py <= ye);
            on_row = ((py >= ys) && (py <= top_hi)) || ((py >= bot_lo) && (py <= ye));
            on_col = ((px >= xs) && (px <= left_hi)) || ((px >= right_lo) && (px <= xe));
            if ((in_x && on_row) || (in_y && on_col)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit interesting(input int y);
        return (y < 5) || (y >= 49 && y <= 52) || (y >= 99 && y <= 105) ||
               (y >= 176 && y <= 178);
    endfunction

    // One input cycle; the expected output is queued for two cycles later.
    task automatic drive(input logic d, input logic hs, input logic vs,
                         input logic [23:0] pix, input int px, input int py);
        exp_t        e;
        logic [23:0] pe;
        @(posedge clk);
        #1;
        de = d; hsync = hs; vsync = vs;
        {r, g, b} = pix;
        bbox_valid = 1'b0;
        done = 1'b0;
        pe = (d && model_hit(px, py)) ? COLOR : pix;
        e.due = cyc + 2;
        e.vec = {d, hs, vs, pe};
        e.px  = px;
        e.py  = py;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
    endtask

    task automatic send_box(input int xs, input int ys, input int xe, input int ye,
                            input logic with_done);
        drive(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
        bbox_valid   = 1'b1;
        bbox_x_start = 16'(xs);
        bbox_y_start = 16'(ys);
        bbox_x_end   = 16'(xe);
        bbox_y_end   = 16'(ye);
        done         = with_done;
    endtask

    task automatic send_done();
        drive(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
        done = 1'b1;
    endtask

    // vsync pulse, then nlines lines; uninteresting lines are one pixel long.
    task automatic run_frame(input int nlines);
        idle(2);
        repeat (2) drive(1'b0, 1'b0, 1'b1, 24'h0, 0, 0);
        idle(2);
        for (int y = 0; y < nlines; y++) begin
            int len;
            len = interesting(y) ? LINE_LEN : 1;
            for (int x = 0; x < len; x++) begin
                drive(1'b1, 1'b0, 1'b0, {x[7:0], y[7:0], 8'h55}, x, y);
            end
            drive(1'b0, 1'b1, 1'b0, 24'h0, 0, 0);
            drive(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
        end
        idle(2);
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_video"}, {de_out, hsync_out, vsync_out, r_out, g_out, b_out}, 64'd0);
        check({tag, "_box_count"}, box_count, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    // Monitor: the stream is continuous, so each queued entry is due on one cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
            check("scoreboard_stale_entry", 64'(sb_q[0].due), 64'(cyc));
            void'(sb_q.pop_front());
        end
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            check($sformatf("video x=%0d y=%0d", e.px, e.py),
                  {de_out, hsync_out, vsync_out, r_out, g_out, b_out}, e.vec);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        bbox_valid = 1'b0; done = 1'b0;
        bbox_x_start = '0; bbox_y_start = '0; bbox_x_end = '0; bbox_y_end = '0;
        de = 1'b1; hsync = 1'b1; vsync = 1'b1; r = 8'hA5; g = 8'hA5; b = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset0");
        de = 1'b0; hsync = 1'b0; vsync = 1'b0; r = '0; g = '0; b = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Empty display: passthrough; then collect one box
        run_frame(NLINES);
        check("empty_box_count", box_count, 0);
        send_box(100, 50, 163, 177, 1'b0);
        send_done();
        idle(1);
        check("pre_swap_box_count", box_count, 0);
        disp_model.push_back('{100, 50, 163, 177});
        run_frame(NLINES);
        check("basic_box_count", box_count, 1);
        check("basic_overflow", overflow, 0);

        // Seventeen boxes: the last is dropped and overflow sticks until swap
        for (int i = 0; i < 17; i++) begin
            send_box(i * 10, 100, i * 10 + 4, 104, 1'b0);
            if (i == 15) begin
                idle(1);
                check("overflow_at_16", overflow, 0);
            end
        end
        idle(1);
        check("overflow_at_17", overflow, 1);
        check("display_count_while_collecting", box_count, 1);
        send_done();
        idle(1);
        check("overflow_after_done", overflow, 1);
        disp_model.delete();
        for (int i = 0; i < 16; i++) disp_model.push_back('{i * 10, 100, i * 10 + 4, 104});
        run_frame(NLINES);
        check("full_box_count", box_count, 16);
        check("overflow_cleared_by_swap", overflow, 0);

        // Invalid boxes, box with done in the same cycle, boxes after commit
        send_box(0, 0, 1280, 3, 1'b0);
        send_box(50, 1, 40, 2, 1'b0);
        send_box(20, 0, 30, 720, 1'b0);
        send_box(0, 0, 3, 3, 1'b1);
        send_box(150, 0, 160, 4, 1'b0);
        send_done();
        idle(1);
        check("overflow_after_committed_drop", overflow, 0);
        check("display_count_before_swap", box_count, 16);
        disp_model.delete();
        disp_model.push_back('{0, 0, 3, 3});
        run_frame(NLINES);
        check("simul_box_count", box_count, 1);

        // Frame without done holds the display; collected boxes wait
        send_box(120, 0, 125, 4, 1'b0);
        send_box(130, 1, 140, 3, 1'b0);
        idle(1);
        run_frame(NLINES);
        check("hold_box_count", box_count, 1);
        send_done();
        disp_model.delete();
        disp_model.push_back('{120, 0, 125, 4});
        disp_model.push_back('{130, 1, 140, 3});
        run_frame(NLINES);
        check("held_then_swapped_box_count", box_count, 2);

        // Reset mid-frame after a commit
        run_frame(6);
        send_box(60, 0, 70, 4, 1'b1);
        idle(2);
        drain();
        reset_n = 1'b0;
        de = 1'b1; hsync = 1'b1; vsync = 1'b1; r = 8'h5A; g = 8'h5A; b = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_mid");
        de = 1'b0; hsync = 1'b0; vsync = 1'b0; r = '0; g = '0; b = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        disp_model.delete();

        // Random video with no boxes: exact 2-cycle passthrough on all channels
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 24'($urandom), 0, 0);
        end
        run_frame(NLINES);
        check("post_reset_box_count", box_count, 0);
        check("post_reset_overflow", overflow, 0);
        idle(3);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
